// File: rtl/ftoi_pipe.sv
// ftoi_pipe: 3-stage float-to-int converter.
// Converts an IEEE-754 single to a 32-bit two's-complement integer, rounding
// to nearest with ties away from zero. Out-of-range values, Inf and NaN
// saturate and raise ovf.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake, x = IEEE-754 single
//   out_valid/out_ready result handshake, y = integer, ovf = saturated
//
// Stages: S1 decode, S2 shift/round, S3 sign/saturate. All stages advance
// together on a single global enable; a stalled output freezes the pipe.
module ftoi_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf
);

  logic       en;
  logic [3:1] vld_pipe;

  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[3];

  // ---------------- S1: decode ----------------
  logic [7:0]  d_e;
  logic [23:0] d_f;
  logic        d_min, d_sat;

  assign d_e   = x[30:23];
  // -2^31 is the only e = 158 value that is representable.
  assign d_min = (x == 32'hCF00_0000);
  assign d_sat = (d_e >= 8'd158) & ~d_min;
  assign d_f   = (d_e != 8'd0) ? {1'b1, x[22:0]} : 24'd0;

  logic        s1_s, s1_sat;
  logic [7:0]  s1_e;
  logic [23:0] s1_f;

  // ---------------- S2: shift / round ----------------
  // r2 = floor(|v| * 2); bit 0 is the first dropped bit used for rounding.
  // Left shift (e - 149) and right shift (149 - e) only need the low 5 bits;
  // 149 mod 32 = 21, so the subtraction is done on e[4:0] directly.
  logic [4:0]  sh_l, sh_r;
  logic [32:0] r2;
  logic [31:0] mag_d;

  assign sh_l = s1_e[4:0] - 5'd21;
  assign sh_r = 5'd21 - s1_e[4:0];

  always_comb begin
    r2 = '0;
    if (s1_e >= 8'd149)
      r2 = {9'd0, s1_f} << sh_l;
    else if (s1_e >= 8'd126)
      r2 = {9'd0, s1_f} >> sh_r;
  end

  assign mag_d = r2[32:1] + {31'd0, r2[0]};

  logic        s2_s, s2_sat;
  logic [31:0] s2_mag;

  // ---------------- S3: sign / saturate ----------------
  logic [31:0] y_d;

  always_comb begin
    if (s2_sat)
      y_d = s2_s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else
      y_d = s2_s ? (~s2_mag + 32'd1) : s2_mag;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_s     <= 1'b0;
      s1_sat   <= 1'b0;
      s1_e     <= '0;
      s1_f     <= '0;
      s2_s     <= 1'b0;
      s2_sat   <= 1'b0;
      s2_mag   <= '0;
      y        <= '0;
      ovf      <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[2:1], in_valid};
      s1_s     <= x[31];
      s1_sat   <= d_sat;
      s1_e     <= d_e;
      s1_f     <= d_f;
      s2_s     <= s1_s;
      s2_sat   <= s1_sat;
      s2_mag   <= mag_d;
      y        <= y_d;
      ovf      <= s2_sat;
    end
  end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Directed bench for ftoi_pipe with a scoreboard queue of {y, ovf}.
module tb_ftoi_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] x = '0;
  logic        in_ready, out_valid, ovf;
  logic [31:0] y;

  ftoi_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [32:0] sbq[$];

  task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] v, input logic [31:0] ey, input logic eo);
    int n = 0;
    x = v;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("send_timeout", {32'd0, in_ready}, 33'd1);
    else sbq.push_back({ey, eo});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("drain_empty", 33'(sbq.size()), 33'd0);
    @(posedge clk); #1;
  endtask

  task automatic latency_check();
    @(negedge clk); chk("lat_c1", {32'd0, out_valid}, 33'd0);
    @(negedge clk); chk("lat_c2", {32'd0, out_valid}, 33'd0);
    @(negedge clk); chk("lat_c3", {32'd0, out_valid}, 33'd1);
    @(posedge clk); #1;
  endtask

  // Output monitor: scoreboard compare, stall stability, in_ready drop.
  logic        stalled = 1'b0;
  logic [32:0] held = '0;

  always @(negedge clk) begin
    if (rst) begin
      stalled <= 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", {32'd0, out_valid}, 33'd1);
        chk("stall_hold", {y, ovf}, held);
      end
      if (out_valid && !out_ready) chk("in_ready_low", {32'd0, in_ready}, 33'd0);
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) chk("unexpected_out", {y, ovf}, 33'h0_0000_0000 ^ {y, ovf} ^ 33'h1);
        else chk("result", {y, ovf}, sbq.pop_front());
      end
      stalled <= out_valid && !out_ready;
      held    <= {y, ovf};
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {32'd0, out_valid}, 33'd0);
    chk("rst_y_ovf", {y, ovf}, 33'd0);
    chk("rst_in_ready", {32'd0, in_ready}, 33'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // single operand with latency check
    send(32'h3FC0_0000, 32'h0000_0002, 1'b0);
    latency_check();

    // directed values, back-to-back
    send(32'hC020_0000, 32'hFFFF_FFFD, 1'b0);
    send(32'h3F00_0000, 32'h0000_0001, 1'b0);
    send(32'h3EFF_FFFF, 32'h0000_0000, 1'b0);
    send(32'h8000_0000, 32'h0000_0000, 1'b0);
    send(32'h4F00_0000, 32'h7FFF_FFFF, 1'b1);
    send(32'hCF00_0000, 32'h8000_0000, 1'b0);
    send(32'hFF80_0000, 32'h8000_0000, 1'b1);
    send(32'h7FC0_0000, 32'h7FFF_FFFF, 1'b1);
    send(32'hBF80_0000, 32'hFFFF_FFFF, 1'b0);
    drain();

    // back-to-back stream
    send(32'h4040_0000, 32'h0000_0003, 1'b0);
    send(32'h4B7F_FFFF, 32'h00FF_FFFF, 1'b0);
    send(32'h4EFF_FFFF, 32'h7FFF_FF80, 1'b0);
    drain();

    // 8 operands with a 4-cycle output stall mid-stream
    fork
      begin
        send(32'h3F80_0000, 32'd1, 1'b0);
        send(32'h4000_0000, 32'd2, 1'b0);
        send(32'h4040_0000, 32'd3, 1'b0);
        send(32'h4080_0000, 32'd4, 1'b0);
        send(32'h40A0_0000, 32'd5, 1'b0);
        send(32'h40C0_0000, 32'd6, 1'b0);
        send(32'h40E0_0000, 32'd7, 1'b0);
        send(32'h4100_0000, 32'd8, 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // reset with three operations in flight
    send(32'h3F80_0000, 32'd1, 1'b0);
    send(32'h4000_0000, 32'd2, 1'b0);
    send(32'h4040_0000, 32'd3, 1'b0);
    rst = 1'b1;
    sbq.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_valid", {32'd0, out_valid}, 33'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no_stale", {32'd0, out_valid}, 33'd0);
    end
    @(posedge clk); #1;
    send(32'h3FC0_0000, 32'h0000_0002, 1'b0);
    latency_check();
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
